// File: rtl/beatmap_pkg.sv
// Shared definitions for the beatmap consumer: FSM encoding, word fields and
// small arithmetic helpers.
package beatmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int WORD_W   = 8;
    localparam int END_BIT  = 7;
    localparam int LANE_LSB = 0;

    function automatic logic [3:0] popcount(input logic [WORD_W-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < WORD_W; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Clamps at max instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] inc,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running scroll-step counter with enable and synchronous clear; strobe
// marks the last cycle of each step.
module step_timer #(
    parameter int STEP_CYCLES = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic strobe
);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        strobe  = en && (count_q == LAST);
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (strobe) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/note_track_scroller.sv
// Scrolls beatmap words down a lane track, judges key presses at the hit row
// and keeps saturating hit/miss totals; also serves rows to the VGA drawer.
module note_track_scroller
    import beatmap_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int ROWS        = 16,
    parameter int STEP_CYCLES = 50,
    parameter int CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      note_valid,
    input  logic [7:0]                note_data,
    output logic                      note_ready,
    input  logic [LANES-1:0]          key,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    output logic [LANES-1:0]          rd_lanes,
    output logic [LANES-1:0]          hit,
    output logic [LANES-1:0]          miss,
    output logic [CNT_W-1:0]          hit_count,
    output logic [CNT_W-1:0]          miss_count,
    output logic                      busy,
    output logic                      done
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    state_t            state_q, state_d;
    logic [LANES-1:0]  track_q [ROWS];
    logic [LANES-1:0]  track_d [ROWS];
    logic [LANES-1:0]  hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [LANES-1:0]  hit_q, hit_d, miss_q, miss_d;
    logic [CNT_W-1:0]  hit_count_q, hit_count_d, miss_count_q, miss_count_d;
    logic [LANES-1:0]  rd_lanes_q, rd_lanes_d;

    logic              active, run_entry, strobe, accept, track_empty;
    logic [LANES-1:0]  hit_vec, miss_vec;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (active),
        .clr    (run_entry),
        .strobe (strobe)
    );

    generate
        if (LANE_LSB + LANES < END_BIT) begin : g_unused
            logic unused_bits;
            assign unused_bits = ^note_data[END_BIT-1:LANE_LSB+LANES];
        end
    endgenerate

    always_comb begin
        active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        run_entry  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        note_ready = (state_q == ST_RUN) && (!hold_full_q || strobe);
        accept     = note_valid && note_ready;

        // Hits are judged first so a key on the strobe cycle rescues the note.
        hit_vec  = active ? (key & track_q[ROWS-1]) : '0;
        miss_vec = (active && strobe) ? (track_q[ROWS-1] & ~hit_vec) : '0;

        track_empty = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if (track_q[r] != '0) track_empty = 1'b0;
        end

        state_d      = state_q;
        track_d      = track_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        hit_d        = hit_vec;
        miss_d       = miss_vec;

        if (run_entry) begin
            state_d      = ST_RUN;
            for (int r = 0; r < ROWS; r++) track_d[r] = '0;
            hold_d       = '0;
            hold_full_d  = 1'b0;
            hit_count_d  = '0;
            miss_count_d = '0;
        end else if (active) begin
            track_d[ROWS-1] = track_q[ROWS-1] & ~hit_vec;
            if (strobe) begin
                for (int r = ROWS - 1; r > 0; r--) track_d[r] = track_q[r-1];
                track_d[0]  = hold_full_q ? hold_q : '0;
                hold_full_d = 1'b0;
            end
            if (accept) begin
                if (note_data[END_BIT]) begin
                    state_d = ST_DRAIN;
                end else begin
                    hold_d      = note_data[LANE_LSB +: LANES];
                    hold_full_d = 1'b1;
                end
            end
            if ((state_q == ST_DRAIN) && track_empty) state_d = ST_DONE;
            hit_count_d  = CNT_W'(sat_add(32'(hit_count_q),
                                          32'(popcount(WORD_W'(hit_vec))), CNT_MAX));
            miss_count_d = CNT_W'(sat_add(32'(miss_count_q),
                                          32'(popcount(WORD_W'(miss_vec))), CNT_MAX));
        end

        rd_lanes_d = '0;
        if (int'(rd_row) < ROWS) rd_lanes_d = track_q[rd_row];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            for (int r = 0; r < ROWS; r++) track_q[r] <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            rd_lanes_q   <= '0;
        end else begin
            state_q      <= state_d;
            track_q      <= track_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            rd_lanes_q   <= rd_lanes_d;
        end
    end

    assign rd_lanes   = rd_lanes_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_track_scroller.sv
// Directed bench for note_track_scroller with ROWS=4, STEP_CYCLES=4: cycle
// index cyc counts rising edges since the start pulse was taken.
module tb_note_track_scroller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       note_valid;
    logic [7:0] note_data;
    logic       note_ready;
    logic [3:0] key;
    logic [1:0] rd_row;
    logic [3:0] rd_lanes;
    logic [3:0] hit;
    logic [3:0] miss;
    logic [7:0] hit_count;
    logic [7:0] miss_count;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    note_track_scroller #(
        .LANES(4), .ROWS(4), .STEP_CYCLES(4), .CNT_W(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .note_valid (note_valid),
        .note_data  (note_data),
        .note_ready (note_ready),
        .key        (key),
        .rd_row     (rd_row),
        .rd_lanes   (rd_lanes),
        .hit        (hit),
        .miss       (miss),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; note_valid = 1'b0; note_data = 8'h00; key = 4'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic feed_one(input logic [7:0] w);
        note_valid = 1'b1; note_data = w;
        tick();
        note_valid = 1'b0; note_data = 8'h00;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; note_valid = 1'b0; note_data = 8'h00;
        key = 4'h0; rd_row = 2'd3;

        // 1: reset state
        tick();
        tick();
        check_eq("rst_hit", 32'(hit), 32'h0);
        check_eq("rst_miss", 32'(miss), 32'h0);
        check_eq("rst_hit_count", 32'(hit_count), 32'h0);
        check_eq("rst_miss_count", 32'(miss_count), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_ready", 32'(note_ready), 32'h0);
        check_eq("rst_rd_lanes", 32'(rd_lanes), 32'h0);
        reset = 1'b0;

        // 2: single note scrolls to the hit row and is missed
        do_start();
        check_eq("s2_busy", 32'(busy), 32'h1);
        check_eq("s2_ready_empty", 32'(note_ready), 32'h1);
        feed_one(8'h01);
        go_to(3);
        check_eq("s2_ready_full_strobe", 32'(note_ready), 32'h1);
        go_to(2 + 0 + 15);
        check_eq("s2_row3_note", 32'(rd_lanes), 32'h1);
        go_to(19);
        check_eq("s2_no_early_miss", 32'(miss), 32'h0);
        go_to(20);
        check_eq("s2_miss", 32'(miss), 32'h1);
        check_eq("s2_miss_count", 32'(miss_count), 32'h1);
        check_eq("s2_hit_count", 32'(hit_count), 32'h0);
        go_to(21);
        check_eq("s2_miss_one_cycle", 32'(miss), 32'h0);

        // 3: key while the note sits in the hit row
        do_reset();
        do_start();
        feed_one(8'h01);
        go_to(17);
        key = 4'b0001;
        tick();
        key = 4'b0000;
        check_eq("s3_hit", 32'(hit), 32'h1);
        check_eq("s3_hit_count", 32'(hit_count), 32'h1);
        tick();
        check_eq("s3_hit_one_cycle", 32'(hit), 32'h0);
        check_eq("s3_row3_cleared", 32'(rd_lanes), 32'h0);
        go_to(20);
        check_eq("s3_no_miss", 32'(miss), 32'h0);
        check_eq("s3_miss_count", 32'(miss_count), 32'h0);

        // 4: key on the strobe that would shift the note out; lane 1 empty
        do_reset();
        do_start();
        feed_one(8'h01);
        go_to(19);
        key = 4'b0011;
        tick();
        key = 4'b0000;
        check_eq("s4_hit", 32'(hit), 32'h1);
        check_eq("s4_miss", 32'(miss), 32'h0);
        check_eq("s4_hit_count", 32'(hit_count), 32'h1);
        check_eq("s4_miss_count", 32'(miss_count), 32'h0);

        // 5: continuous valid, one word per step, then end marker and drain
        do_reset();
        do_start();
        note_valid = 1'b1; note_data = 8'h0F;
        for (int c = 0; c < 12; c++) begin
            check_eq($sformatf("s5_ready_c%0d", c), 32'(note_ready),
                     32'((c == 0) || (c % 4 == 3)));
            tick();
        end
        note_data = 8'h80;
        go_to(15);
        check_eq("s5_ready_end", 32'(note_ready), 32'h1);
        tick();
        note_valid = 1'b0; note_data = 8'h00;
        check_eq("s5_drain_ready", 32'(note_ready), 32'h0);
        check_eq("s5_drain_busy", 32'(busy), 32'h1);
        check_eq("s5_drain_done", 32'(done), 32'h0);
        go_to(20);
        check_eq("s5_drain_miss", 32'(miss), 32'hF);
        go_to(32);
        check_eq("s5_miss_count", 32'(miss_count), 32'd16);
        check_eq("s5_not_done_yet", 32'(done), 32'h0);
        tick();
        check_eq("s5_done", 32'(done), 32'h1);
        check_eq("s5_busy", 32'(busy), 32'h0);
        check_eq("s5_done_ready", 32'(note_ready), 32'h0);

        // 6: hit_count saturation, then reset in DRAIN
        do_start();
        check_eq("s6_restart_count", 32'(miss_count), 32'h0);
        note_valid = 1'b1; note_data = 8'h0F; key = 4'hF;
        go_to(268);
        check_eq("s6_hit_252", 32'(hit_count), 32'd252);
        go_to(269);
        check_eq("s6_hit_sat", 32'(hit_count), 32'd255);
        go_to(300);
        check_eq("s6_hit_stays", 32'(hit_count), 32'd255);
        check_eq("s6_no_miss", 32'(miss_count), 32'h0);
        note_data = 8'h80;
        go_to(304);
        note_valid = 1'b0; note_data = 8'h00;
        check_eq("s6_drain_busy", 32'(busy), 32'h1);
        check_eq("s6_drain_ready", 32'(note_ready), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0; key = 4'h0;
        check_eq("s6_rst_hit_count", 32'(hit_count), 32'h0);
        check_eq("s6_rst_miss_count", 32'(miss_count), 32'h0);
        check_eq("s6_rst_busy", 32'(busy), 32'h0);
        check_eq("s6_rst_done", 32'(done), 32'h0);
        check_eq("s6_rst_hit", 32'(hit), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/note_track_scroller.md
Name: note_track_scroller

Overview:
Downstream consumer of the double-buffered beatmap byte stream. It accepts one 8-bit beatmap word per scroll step and shifts it into a ROWS-deep lane track. It judges player key presses at the bottom (hit) row and counts hits and misses. It also exposes a registered row read port for the VGA lane drawer.

Parameters:
LANES, 4, number of note lanes; word bits [LANES-1:0] are the lane note flags.
ROWS, 16, track depth; row 0 is the top/entry row, row ROWS-1 is the hit row.
STEP_CYCLES, 50, clk cycles per scroll step; must be >= 2.
CNT_W, 8, width of the hit and miss counters.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a song from IDLE or DONE
note_valid  in  1  beatmap word available
note_data  in  8  bit7 = end-of-map marker; bits[LANES-1:0] = lane notes; other bits ignored
note_ready  out  1  word accepted this cycle when note_valid && note_ready
key  in  LANES  per-lane key pulses, already debounced, one cycle per press
rd_row  in  $clog2(ROWS)  row address for the VGA drawer
rd_lanes  out  LANES  contents of rd_row, registered, latency 1
hit  out  LANES  one-cycle per-lane hit pulse
miss  out  LANES  one-cycle per-lane miss pulse
hit_count  out  CNT_W  total hits, saturating
miss_count  out  CNT_W  total misses, saturating
busy  out  1  high in RUN and DRAIN
done  out  1  high in DONE

Behaviour:
- Reset values: all outputs 0, all track rows 0, holding register empty, step counter 0, state IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE -> RUN on start. Entering RUN clears the track, the counters, the holding register and the step counter.
  - RUN -> DRAIN when a word with bit7=1 is accepted. That word's lane bits are discarded.
  - DRAIN -> DONE on the first cycle the whole track is zero.
  - start in RUN or DRAIN is ignored.
- Step counter:
  - Counts 0..STEP_CYCLES-1 in RUN and DRAIN only.
  - The step strobe fires on the cycle the count equals STEP_CYCLES-1, and the count wraps to 0.
- Input handshake:
  - One-entry holding register.
  - note_ready = 1 in RUN when the holding register is empty, or when it is full and the step strobe fires in the same cycle (pass-through).
  - note_ready = 0 in IDLE, DRAIN and DONE.
- On the step strobe:
  - Row r+1 <= row r for r = 0..ROWS-2.
  - Row 0 <= holding register lane bits if full, else 0 (underflow inserts a blank row and is not an error).
  - The holding register empties on that strobe.
  - Any set bit in the old row ROWS-1 produces a miss pulse for that lane on the same-edge registered output. miss_count increments by the popcount of those bits.
- Key judgement (every cycle in RUN/DRAIN, evaluated before the step shift):
  - For each lane with key=1 and hit-row bit=1: hit pulse, clear that bit, hit_count += 1.
  - A key on an empty hit row does nothing (no penalty).
  - If a key and the step strobe coincide on a set hit-row bit, the hit wins: the bit is cleared and no miss is generated for that lane.
- Counters:
  - Each count adds its per-cycle popcount (0..LANES).
  - Counters saturate at 2^CNT_W-1 and never wrap.
- rd_lanes:
  - Registered read of the current track.
  - Returns the pre-shift value if read on the strobe cycle.
  - Out-of-range rd_row returns 0.
- Reset mid-song returns to IDLE with everything cleared on the next edge.
- hit and miss are 0 in IDLE and DONE; keys are ignored there.

Decomposition:
- Shared package beatmap_pkg holds:
  - the FSM state encoding;
  - the word field constants (END_BIT = 7, lane field LSB = 0);
  - a popcount function and a saturating-add function.
- One natural sub-module: step_timer (STEP_CYCLES counter with enable, synchronous clear and strobe output).

Test Plan:
1. reset=1 for 2 cycles, with ROWS=4, STEP_CYCLES=4 -> all outputs 0, state IDLE, note_ready=0.
2. start; feed 0x01 then blanks, no keys -> after 4 strobes the lane-0 bit reaches row 3; on strobe 5 miss=4'b0001 for one cycle and miss_count=1.
3. Same as scenario 2, but key[0] pulsed while row 3 holds the note -> hit=4'b0001, hit_count=1, no miss on the following strobe; rd_row=3 reads 0 after the hit.
4. key[0] pulsed on the exact strobe cycle that would shift the note out -> hit, no miss; key[1] on an empty lane -> no pulse.
5. Hold note_valid with 0x0F continuously -> exactly one word accepted per step and note_ready drops between strobes. Then send 0x80 -> DRAIN, note_ready=0; after the track empties, done=1 and busy=0.
6. Force hit_count to 255 (CNT_W=8) via repeated hits -> it stays 255. Assert reset in DRAIN -> IDLE and all counts 0 on the next cycle.
